// File: rtl/fifo_rd_ptr_empty_if.sv
// Read-side bundle of the async FIFO: consumer request, synchronized
// write pointer in; read address, Gray pointer and status flags out.
interface fifo_rd_ptr_empty_if #(
    parameter int ADDR_W = 3,
    parameter int PW     = ADDR_W + 1
);
    logic              rd_en;
    logic [PW-1:0]     wptr_gray_sync;
    logic [ADDR_W-1:0] raddr;
    logic [PW-1:0]     rptr_gray;
    logic              empty;
    logic              almost_empty;
    logic [PW-1:0]     rd_level;
    logic              rd_valid;
    logic              underflow;

    modport master (
        output rd_en,
        output wptr_gray_sync,
        input  raddr,
        input  rptr_gray,
        input  empty,
        input  almost_empty,
        input  rd_level,
        input  rd_valid,
        input  underflow
    );

    modport slave (
        input  rd_en,
        input  wptr_gray_sync,
        output raddr,
        output rptr_gray,
        output empty,
        output almost_empty,
        output rd_level,
        output rd_valid,
        output underflow
    );
endinterface

// File: rtl/fifo_rd_ptr_empty.sv
// Async FIFO read-domain pointer: binary/Gray read pointer, registered
// empty, level and almost_empty against the synchronized write pointer.
module fifo_rd_ptr_empty #(
    parameter int ADDR_W    = 3,
    parameter int AE_THRESH = 2,
    parameter int PW        = ADDR_W + 1
) (
    input logic                 clk,
    input logic                 rst,
    fifo_rd_ptr_empty_if.slave  bus
);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b         = '0;
        b[PW-1]   = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic [PW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic          uf_q, uf_d;

    logic          rd_accept;
    logic [PW-1:0] wbin;

    // Reads are gated by the registered empty, so a read past empty is never taken.
    always_comb begin
        rd_accept = bus.rd_en & ~empty_q;
        wbin      = gray2bin(bus.wptr_gray_sync);
        rbin_d    = rbin_q + {{(PW-1){1'b0}}, rd_accept};
        rgray_d   = rbin_d ^ (rbin_d >> 1);
        empty_d   = (rgray_d == bus.wptr_gray_sync);
        level_d   = wbin - rbin_d;
        ae_d      = (level_d <= PW'(AE_THRESH));
        valid_d   = rd_accept;
        uf_d      = uf_q | (bus.rd_en & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            level_q <= '0;
            valid_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            level_q <= level_d;
            valid_q <= valid_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.raddr        = rbin_q[ADDR_W-1:0];
    assign bus.rptr_gray    = rgray_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_level     = level_q;
    assign bus.rd_valid     = valid_q;
    assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for fifo_rd_ptr_empty: occupancy-count reference model,
// expectations queued per cycle and checked by an independent monitor.
module tb_fifo_rd_ptr_empty;

    localparam int ADDR_W = 3;
    localparam int PW     = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int AE     = 2;

    typedef struct {
        int raddr;
        int gray;
        int empty;
        int ae;
        int level;
        int valid;
        int uf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_rd_ptr_empty_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_rd_ptr_empty #(.ADDR_W(ADDR_W), .AE_THRESH(AE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: total writes made visible and total reads accepted.
    int wcnt   = 0;
    int rdcnt  = 0;
    int m_empty = 1;
    int m_uf    = 0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & ((1 << PW) - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rd, input int wadd);
        exp_t e;
        int   acc;
        int   lvl;
        @(negedge clk);
        acc   = (rd && m_empty == 0) ? 1 : 0;
        if (rd && m_empty == 1) m_uf = 1;
        rdcnt += acc;
        wcnt  += wadd;
        lvl   = wcnt - rdcnt;
        bus.rd_en          = rd;
        bus.wptr_gray_sync = PW'(gray(wcnt % (2 * DEPTH)));
        m_empty  = (lvl == 0) ? 1 : 0;
        e.raddr  = rdcnt % DEPTH;
        e.gray   = gray(rdcnt % (2 * DEPTH));
        e.empty  = m_empty;
        e.ae     = (lvl <= AE) ? 1 : 0;
        e.level  = lvl;
        e.valid  = acc;
        e.uf     = m_uf;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.rd_en = 1'b0;
        #1;
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_ae", int'(bus.almost_empty), 1);
        chk("rst_gray", int'(bus.rptr_gray), 0);
        chk("rst_raddr", int'(bus.raddr), 0);
        chk("rst_level", int'(bus.rd_level), 0);
        chk("rst_valid", int'(bus.rd_valid), 0);
        chk("rst_uf", int'(bus.underflow), 0);
        bus.wptr_gray_sync = '0;
        wcnt    = 0;
        rdcnt   = 0;
        m_empty = 1;
        m_uf    = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: the DUT presents a fresh status word after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("raddr", int'(bus.raddr), e.raddr);
                chk("rptr_gray", int'(bus.rptr_gray), e.gray);
                chk("empty", int'(bus.empty), e.empty);
                chk("almost_empty", int'(bus.almost_empty), e.ae);
                chk("rd_level", int'(bus.rd_level), e.level);
                chk("rd_valid", int'(bus.rd_valid), e.valid);
                chk("underflow", int'(bus.underflow), e.uf);
            end
        end
    end

    initial begin
        int rd;
        int room;
        bus.rd_en          = 1'b0;
        bus.wptr_gray_sync = '0;
        #12;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1);
        do_reset();

        // Fill to 3, drain with three reads, then one over-read.
        cycle(1'b0, 3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        cycle(1'b0, 0);
        cycle(1'b1, 0);
        cycle(1'b0, 0);

        // Full FIFO, drain with wrap, refill and 16 total reads.
        do_reset();
        cycle(1'b0, 8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 0);
        cycle(1'b0, 8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 0);
        cycle(1'b0, 0);

        // almost_empty threshold with a concurrent write.
        cycle(1'b0, 3);
        cycle(1'b1, 0);
        cycle(1'b1, 2);
        // Last entry read while a new one arrives.
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        cycle(1'b1, 1);
        cycle(1'b0, 0);

        for (int i = 0; i < 3000; i++) begin
            rd   = ($urandom_range(0, 99) < 60) ? 1 : 0;
            room = DEPTH - (wcnt - rdcnt);
            if (rd == 1 && m_empty == 0) room++;
            cycle(rd[0], $urandom_range(0, (room < 3) ? room : 3));
            if (i % 997 == 500) do_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
